// File: rtl/booth_radix2_seq.sv
// Sequential 16x16 signed radix-2 Booth multiplier: one recode/add/shift step per clock.
// A 17-bit accumulator keeps -32768 operands exact.
module booth_radix2_seq #(
  parameter int WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WIDTH-1:0]       mcand_i,
  input  logic [WIDTH-1:0]       mplier_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2*WIDTH-1:0]     product_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [4:0]     LAST_STEP = 5'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE       = {{WIDTH{1'b0}}, 1'b1};

  state_t               state_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 q1_q;
  logic [WIDTH:0]       mcand_q;
  logic [4:0]           cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_d;
  logic [WIDTH-1:0]     mplier_d;

  // Booth recode of {Q[0],q1}, then arithmetic right shift of {T,Q,q1}.
  always_comb begin
    sum = acc_q;
    unique case ({mplier_q[0], q1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q + ~mcand_q + ONE;
      default: sum = acc_q;
    endcase
    acc_d    = {sum[WIDTH], sum[WIDTH:1]};
    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mplier_q  <= '0;
      q1_q      <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            mcand_q  <= {mcand_i[WIDTH-1], mcand_i};
            acc_q    <= '0;
            mplier_q <= mplier_i;
            q1_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= CALC;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          q1_q     <= mplier_q[0];
          cnt_q    <= cnt_q + 5'd1;
          // Final step: A[16] is only a sign copy, so the product is A[15:0]:Q.
          if (cnt_q == LAST_STEP) begin
            product_q <= {acc_d[WIDTH-1:0], mplier_d};
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_booth_radix2_seq.sv
// Scoreboard bench for booth_radix2_seq: stimulus pushes expected products,
// a monitor pops and checks them (value and 16-cycle latency) on each rising done.
module tb_booth_radix2_seq;

  typedef struct {
    logic [31:0] prod;
    int          acceptCycle;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] mcand;
  logic signed [15:0] mplier;
  logic               busy;
  logic               done;
  logic [31:0]        product;

  int   checks;
  int   failures;
  int   cycleCount;
  logic donePrev;
  exp_t sbQ[$];

  booth_radix2_seq #(.WIDTH(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .mcand_i   (mcand),
    .mplier_i  (mplier),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount = cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done rises and checks value and latency.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
    if (rst) begin
      donePrev = 1'b0;
    end else begin
      if (done && !donePrev) begin
        checks = checks + 1;
        if (sbQ.size() == 0) begin
          failures = failures + 1;
          $display("[TB] FAIL unexpected_done: got product 0x%08h with empty scoreboard", product);
        end else begin
          checks = checks - 1;
          e = sbQ.pop_front();
          checkOutput("product", product, e.prod);
          checkOutput("latency", 32'(cycleCount - e.acceptCycle), 32'd16);
        end
      end
      donePrev = done;
    end
  end

  // Drives one start pulse and records the expected result against the accepting edge.
  task automatic applyStimulus(input logic signed [15:0] mc, input logic signed [15:0] mp,
                               input logic [31:0] expProd);
    exp_t e;
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    @(posedge clk);
    #1;
    e.prod        = expProd;
    e.acceptCycle = cycleCount;
    sbQ.push_back(e);
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    exp_t e;
    checks     = 0;
    failures   = 0;
    cycleCount = 0;
    donePrev   = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    mcand      = '0;
    mplier     = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_product", product, 32'd0);
    rst = 1'b0;

    applyStimulus(16'sd3, 16'sd5, 32'h0000000F);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("done_holds", {31'd0, done}, 32'd1);
    checkOutput("product_holds", product, 32'h0000000F);

    applyStimulus(-16'sd7, 16'sd6, 32'hFFFFFFD6);
    waitDone();
    applyStimulus(16'sd32767, -16'sd32768, 32'hC0008000);
    waitDone();
    applyStimulus(-16'sd32768, -16'sd32768, 32'h40000000);
    waitDone();
    applyStimulus(16'sd0, -16'sd1, 32'h00000000);
    waitDone();
    applyStimulus(-16'sd1, -16'sd1, 32'h00000001);
    waitDone();

    // Start pulse with new operands mid-sequence must be ignored.
    applyStimulus(16'sd7, -16'sd3, 32'hFFFFFFEB);
    repeat (5) @(negedge clk);
    mcand  = 16'sd100;
    mplier = 16'sd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();

    // Back-to-back: start held high, second operands picked up one edge after done.
    @(negedge clk);
    mcand  = -16'sd7;
    mplier = 16'sd6;
    start  = 1'b1;
    @(posedge clk);
    #1;
    e.prod        = 32'hFFFFFFD6;
    e.acceptCycle = cycleCount;
    sbQ.push_back(e);
    mcand  = 16'sd100;
    mplier = -16'sd100;
    waitDone();
    @(posedge clk);
    #1;
    e.prod        = 32'hFFFFD8F0;
    e.acceptCycle = cycleCount;
    sbQ.push_back(e);
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_done_drops", {31'd0, done}, 32'd0);
    checkOutput("b2b_busy_rises", {31'd0, busy}, 32'd1);
    waitDone();

    // Asynchronous reset between edges during iteration 8.
    @(negedge clk);
    mcand  = 16'sd11;
    mplier = 16'sd13;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_done", {31'd0, done}, 32'd0);
    checkOutput("async_rst_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'sd3, 16'sd5, 32'h0000000F);
    waitDone();

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_radix2_seq.md
# booth_radix2_seq

Sequential 16×16 signed radix-2 Booth multiplier control and datapath for the booth multiplier path. It retires one Booth step per clock through an internal 17-bit add/subtract stage. It also owns operand capture, the recode/shift sequence and the start/done handshake. It produces the 32-bit two's-complement product that downstream logic consumes.

## Interface
- `WIDTH`, 16: operand width. Only 16 is supported; the datapath is `WIDTH+1` = 17 bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin a multiply; sampled on the rising edge.
- `mcand`  in  16  signed multiplicand; captured on an accepted start.
- `mplier`  in  16  signed multiplier; captured on an accepted start.
- `busy`  out  1  high while an iteration sequence is in progress.
- `done`  out  1  high while `product` holds a completed result.
- `product`  out  32  signed product of the last completed operation.

## Operation
- **States:** IDLE, CALC, DONE.
- **Registers:** `A[16:0]` accumulator, `Q[15:0]`, `q1` (1 bit), `M[16:0]`, `cnt[4:0]`, `product[31:0]`.
- **IDLE or DONE with `start`=1:**
  - `M` ← sign-extend(`mcand`), `A` ← 0, `Q` ← `mplier`, `q1` ← 0, `cnt` ← 0.
  - Go to CALC; `busy` ← 1, `done` ← 0.
  - `product` keeps its old value.
- **CALC, each cycle:**
  - Recode `{Q[0],q1}`: 00 or 11 → T = A; 01 → T = A + M; 10 → T = A − M.
  - Subtraction is A + ~M + 1. All arithmetic is 17-bit and wraps modulo 2^17; no overflow flag.
  - Arithmetic right shift of `{T,Q,q1}` by one, with `T[16]` replicated:
    - `A` ← `{T[16],T[16:1]}`
    - `Q` ← `{T[0],Q[15:1]}`
    - `q1` ← `Q[0]`
  - `cnt` ← `cnt`+1.
- **Last CALC cycle (`cnt`=15):**
  - The shift above still executes.
  - `product` ← `{A_next[15:0], Q_next}`.
  - Go to DONE; `busy` ← 0, `done` ← 1.
- **DONE:** outputs hold until the next accepted start. There is no acknowledge input.
- **`start` during CALC:** ignored; operands are not recaptured and the sequence is not disturbed.
- **Operand changes after capture:** `mcand`/`mplier` changes have no effect.
- **17-bit accumulator:** guarantees a correct result for `mcand` = −32768, including −32768 × −32768 = +2^30.
- **Reset (any time, including mid-CALC):**
  - State → IDLE.
  - `A`, `Q`, `q1`, `M`, `cnt`, `product` → 0.
  - `busy` = 0, `done` = 0.
  - The partial result is discarded.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `product` = 0, state IDLE.
- **Start to busy:** `start` sampled at edge E0 → `busy` = 1 after E0.
- **Iterations:** the 16 iterations occur at edges E1..E16.
- **Completion:** after E16, `done` = 1, `busy` = 0 and `product` is valid.
- **Latency:** 16 cycles from the accepting edge to `done`.
- **Back-to-back:** `start` held high in DONE is accepted on the next edge. `done` drops and `busy` rises after that edge, so minimum initiation interval is 17 cycles.
- **Registered outputs:** `busy`, `done` and `product` are registered, with no combinational path from inputs.
- **Exclusivity:** `busy` and `done` are never high together.

## Test plan
- **Basic positive:** reset, then start with `mcand`=3, `mplier`=5 → `done` exactly 16 cycles after the accepting edge, `product` = 32'h0000000F.
- **Sign mix:**
  - −7 × 6 → 32'hFFFFFFD6 (−42).
  - 32767 × −32768 → 32'hC0008000 (−1073709056).
- **Corner operands:**
  - −32768 × −32768 → 32'h40000000.
  - 0 × −1 → 0.
  - −1 × −1 → 1.
- **Start while busy:** pulse `start` with new operands mid-CALC → ignored; original product appears at cycle 16.
- **Back-to-back:** hold `start` high through DONE with 100 × −100 → second accept one cycle after `done`; `product` = 32'hFFFFD8F0.
- **Async reset mid-CALC:** assert `rst` between clock edges at iteration 8 → `busy`/`done`/`product` zero immediately; after release, 3 × 5 completes normally.
